// File: rtl/multiplicador_if.sv
// Handshake and operand/result bundle for the sequential multiplier.
// master drives the request side; slave is the multiplier itself.
interface multiplicador_if #(
    parameter int unsigned LARGURA = 16
);
    logic               inicio;
    logic               sinal;
    logic [LARGURA-1:0] operando1;
    logic [LARGURA-1:0] operando2;
    logic               ocupado;
    logic               pronto;
    logic [LARGURA-1:0] res_low;
    logic [LARGURA-1:0] res_high;

    modport master (
        output inicio, sinal, operando1, operando2,
        input  ocupado, pronto, res_low, res_high
    );

    modport slave (
        input  inicio, sinal, operando1, operando2,
        output ocupado, pronto, res_low, res_high
    );
endinterface

// File: rtl/multiplicador.sv
// Radix-2 shift-and-add multiplier, LARGURA iterations per product.
// Define MULT_SIGNED_EN to honour sinal (two's-complement operands).
module multiplicador #(
    parameter int unsigned LARGURA = 16
) (
    input logic            clock,
    input logic            reset,
    multiplicador_if.slave bus
);
    localparam int unsigned LargP = 2 * LARGURA;
    localparam int unsigned CntW  = $clog2(LARGURA + 1);

    typedef enum logic {StOcioso, StCalcula} estado_t;

    estado_t            r_estado, w_estado_d;
    logic [LargP-1:0]   r_mcand, w_mcand_d;
    logic [LARGURA-1:0] r_mplier, w_mplier_d;
    logic [LargP-1:0]   r_acc, w_acc_d;
    logic [CntW-1:0]    r_cont, w_cont_d;
    logic               r_ocupado, w_ocupado_d;
    logic               r_pronto, w_pronto_d;
    logic [LargP-1:0]   r_res, w_res_d;

    logic [LARGURA-1:0] w_mag1, w_mag2;
    logic               w_neg;
    logic [LargP-1:0]   w_soma;
    logic [LargP-1:0]   w_final;

`ifdef MULT_SIGNED_EN
    logic r_neg, w_neg_d;

    // 0x8000 negates to itself, which is the correct unsigned magnitude.
    assign w_mag1 = (bus.sinal && bus.operando1[LARGURA-1]) ? -bus.operando1 : bus.operando1;
    assign w_mag2 = (bus.sinal && bus.operando2[LARGURA-1]) ? -bus.operando2 : bus.operando2;
    assign w_neg_d = (r_estado == StOcioso && bus.inicio)
                   ? (bus.sinal & (bus.operando1[LARGURA-1] ^ bus.operando2[LARGURA-1]))
                   : r_neg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_neg <= 1'b0;
        end else begin
            r_neg <= w_neg_d;
        end
    end

    assign w_neg = r_neg;
`else
    logic w_sinal_unused;
    assign w_sinal_unused = bus.sinal;
    assign w_mag1         = bus.operando1;
    assign w_mag2         = bus.operando2;
    assign w_neg          = 1'b0;
`endif

    assign w_soma  = r_acc + (r_mplier[0] ? r_mcand : {LargP{1'b0}});
    assign w_final = w_neg ? -w_soma : w_soma;

    always_comb begin
        w_estado_d  = r_estado;
        w_mcand_d   = r_mcand;
        w_mplier_d  = r_mplier;
        w_acc_d     = r_acc;
        w_cont_d    = r_cont;
        w_ocupado_d = r_ocupado;
        w_pronto_d  = 1'b0;
        w_res_d     = r_res;
        case (r_estado)
            StOcioso: begin
                if (bus.inicio) begin
                    w_mcand_d   = {{LARGURA{1'b0}}, w_mag1};
                    w_mplier_d  = w_mag2;
                    w_acc_d     = '0;
                    w_cont_d    = CntW'(LARGURA);
                    w_ocupado_d = 1'b1;
                    w_estado_d  = StCalcula;
                end
            end
            StCalcula: begin
                w_acc_d    = w_soma;
                w_mcand_d  = r_mcand << 1;
                w_mplier_d = r_mplier >> 1;
                w_cont_d   = r_cont - 1'b1;
                // Last iteration publishes its own sum directly.
                if (r_cont == CntW'(1)) begin
                    w_res_d     = w_final;
                    w_pronto_d  = 1'b1;
                    w_ocupado_d = 1'b0;
                    w_estado_d  = StOcioso;
                end
            end
            default: w_estado_d = StOcioso;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado  <= StOcioso;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cont    <= '0;
            r_ocupado <= 1'b0;
            r_pronto  <= 1'b0;
            r_res     <= '0;
        end else begin
            r_estado  <= w_estado_d;
            r_mcand   <= w_mcand_d;
            r_mplier  <= w_mplier_d;
            r_acc     <= w_acc_d;
            r_cont    <= w_cont_d;
            r_ocupado <= w_ocupado_d;
            r_pronto  <= w_pronto_d;
            r_res     <= w_res_d;
        end
    end

    assign bus.ocupado  = r_ocupado;
    assign bus.pronto   = r_pronto;
    assign bus.res_low  = r_res[LARGURA-1:0];
    assign bus.res_high = r_res[LargP-1:LARGURA];
endmodule

// File: doc/multiplicador.md
# multiplicador

Sequential 16x16 multiplier that produces the 32-bit product consumed by the ALU's HI/LO move operations. The product appears as a low half and a high half on `res_low` and `res_high`. The block uses a radix-2 shift-and-add datapath with a start/busy/done handshake. It sits beside the operand-read stage: it receives the same `operando1`/`operando2` values and holds its result until the next multiplication completes.

## Interface
- `LARGURA`, 16: operand width; product width is 2*LARGURA, iteration count is LARGURA.
- `clock`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-low; clears all state and outputs.
- `inicio`  in  1: start request, sampled on rising edge.
- `sinal`  in  1: 1 = two's-complement operands, 0 = unsigned (see Configuration).
- `operando1`  in  LARGURA: multiplicand.
- `operando2`  in  LARGURA: multiplier.
- `ocupado`  out  1: high while a multiplication is in progress.
- `pronto`  out  1: one-cycle pulse when a new result is valid.
- `res_low`  out  LARGURA: product bits [LARGURA-1:0].
- `res_high`  out  LARGURA: product bits [2*LARGURA-1:LARGURA].

## Operation
- States: OCIOSO (idle) and CALCULA (iterating). Reset enters OCIOSO.
- Reset values: `ocupado`=0, `pronto`=0, `res_low`=0, `res_high`=0, iteration counter=0.
- Start sequence:
  - In OCIOSO, `inicio`=1 captures the operands and `sinal`.
  - Signed mode only: operands are converted to magnitudes and the sign XOR is latched.
  - The 2*LARGURA accumulator clears, the counter loads LARGURA, and the state moves to CALCULA.
- Each CALCULA cycle:
  - If multiplier LSB=1, add the shifted multiplicand to the accumulator.
  - Shift the multiplicand left and the multiplier right; decrement the counter.
- Completion, on the cycle the counter reaches 0:
  - Write the final accumulator to `res_high`/`res_low`, negated if the latched sign XOR is 1.
  - Pulse `pronto`, clear `ocupado`, return to OCIOSO.
- Arithmetic: all internal sums are 2*LARGURA bits wide and overflow is impossible. For LARGURA=16 with both operands -32768, the magnitude 0x8000 is treated as unsigned.
- `inicio` while in CALCULA is ignored. No queueing; operands are not re-sampled.
- `inicio`=1 in the cycle `pronto` is high: accepted, because the state is already OCIOSO.
- `res_low`/`res_high` hold the last completed result until the next completion. They never expose partial values.
- Operand changes after the capture edge have no effect.
- Reset asserted mid-operation: the computation is aborted immediately and all outputs return to reset values. No `pronto` is produced.

## Timing
- Start captured at rising edge k: `ocupado`=1 after edge k.
- Iterations occur at edges k+1 … k+LARGURA.
- At edge k+LARGURA (k+16): results are updated, `pronto`=1, `ocupado`=0.
- `pronto` falls after edge k+LARGURA+1 unless a new completion occurs.
- Latency from start edge to result: LARGURA cycles.
- Maximum throughput: one product per LARGURA cycles, with back-to-back starts allowed.
- Outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `MULT_SIGNED_EN`:
  - Defined: `sinal` is honoured as described above, including magnitude conversion and final negation.
  - Undefined: `sinal` is ignored and every multiplication is unsigned. The sign-handling logic is not synthesized. Port list is identical in both builds.

## Test plan
- Reset then idle: `res_low`=0x0000, `res_high`=0x0000, `ocupado`=0, `pronto`=0; `inicio` held low for 20 cycles -> no change.
- Unsigned 0xFFFF × 0xFFFF, `sinal`=0 -> after 16 cycles `res_high`=0xFFFE, `res_low`=0x0001, `pronto` high for exactly one cycle.
- Signed build, `sinal`=1:
  - -1 × 1 -> 0xFFFF/0xFFFF.
  - -32768 × -32768 -> 0x4000/0x0000.
  - -32768 × 1 -> 0xFFFF/0x8000.
- Unsigned build, `sinal`=1, 0xFFFF × 0x0001 -> 0x0000/0xFFFF.
- Start 3 × 5, pulse `inicio` with 7 × 9 at cycle 5 -> first result 0x0000/0x000F; second request ignored, no second `pronto`. Then `inicio` with 7 × 9 in the `pronto` cycle -> 0x0000/0x003F exactly 16 cycles later.
- Start 1234 × 5678, assert `reset` low at cycle 8 for one cycle -> outputs 0 immediately, no `pronto`. A fresh 2 × 3 afterwards -> 0x0000/0x0006.
